// File: rtl/sc_bs_accumulator.sv
// Popcount-accumulates a programmed number of stochastic bitstream chunks back to binary.
// Latency: result_valid two edges after the last accepted chunk. bs_ready only in ACC.
module sc_bs_accumulator #(
  parameter int IN_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CHUNK_WIDTH-1:0] num_chunks,
  input  logic [IN_WIDTH-1:0]    bs_in,
  input  logic                   bs_valid,
  output logic                   bs_ready,
  output logic [CNT_WIDTH-1:0]   result,
  output logic                   result_valid,
  output logic                   busy
);
  localparam int PC_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   acc;
  logic [PC_W-1:0]        pc_reg;
  logic [PC_W-1:0]        pc_next;
  logic                   pc_valid;
  logic [CHUNK_WIDTH-1:0] beat_cnt;
  logic [CHUNK_WIDTH-1:0] num_lat;
  logic [CNT_WIDTH:0]     acc_wide;
  logic [CNT_WIDTH-1:0]   acc_sum;
  logic                   accept;
  logic                   last_beat;

  always_comb begin
    pc_next = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      pc_next = pc_next + PC_W'(bs_in[i]);
    end
  end

  // One spare bit catches overflow so the sum can clamp to all-ones.
  always_comb begin
    acc_wide = {1'b0, acc} + (CNT_WIDTH + 1)'(pc_reg);
    acc_sum  = acc_wide[CNT_WIDTH] ? '1 : acc_wide[CNT_WIDTH-1:0];
  end

  assign accept    = bs_valid && bs_ready;
  assign last_beat = (beat_cnt == num_lat - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      pc_reg       <= '0;
      pc_valid     <= 1'b0;
      beat_cnt     <= '0;
      num_lat      <= '0;
      bs_ready     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_lat  <= num_chunks;
            acc      <= '0;
            beat_cnt <= '0;
            pc_valid <= 1'b0;
            busy     <= 1'b1;
            if (num_chunks != '0) begin
              state    <= ACC;
              bs_ready <= 1'b1;
            end else begin
              state        <= DONE;
              result       <= '0;
              result_valid <= 1'b1;
            end
          end
        end
        ACC: begin
          pc_valid <= accept;
          if (pc_valid) acc <= acc_sum;
          if (accept) begin
            pc_reg   <= pc_next;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state    <= DRAIN;
              bs_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last popcount is always pending here; fold it straight into result.
          acc          <= acc_sum;
          result       <= acc_sum;
          pc_valid     <= 1'b0;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sc_bs_accumulator.sv
// Scoreboard bench for sc_bs_accumulator: default instance plus an 8-bit saturating instance.
module tb_sc_bs_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  num_chunks = '0;
  logic [31:0] bs_in = '0;
  logic        bs_valid = 1'b0;
  logic        rdy0, rv0, busy0, rdy1, rv1, busy1;
  logic [15:0] res0;
  logic [7:0]  res1;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_q1[$];
  logic [31:0] chunk_mem[0:255];
  logic [15:0] exp_v;
  logic [7:0]  exp_v1;

  always #5 clk = ~clk;

  sc_bs_accumulator dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_chunks(num_chunks), .bs_in(bs_in),
    .bs_valid(bs_valid), .bs_ready(rdy0), .result(res0), .result_valid(rv0), .busy(busy0)
  );

  sc_bs_accumulator #(.CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_chunks(num_chunks), .bs_in(bs_in),
    .bs_valid(bs_valid), .bs_ready(rdy1), .result(res1), .result_valid(rv1), .busy(busy1)
  );

  // Every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rv0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse dut0 result=%0d with nothing expected", res0);
      end else begin
        exp_v = exp_q.pop_front();
        if (res0 !== exp_v) begin
          failures++;
          $display("FAIL result dut0 got=%0d exp=%0d", res0, exp_v);
        end
      end
    end
    if (rv1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse dut1 result=%0d with nothing expected", res1);
      end else begin
        exp_v1 = exp_q1.pop_front();
        if (res1 !== exp_v1) begin
          failures++;
          $display("FAIL result dut1 got=%0d exp=%0d", res1, exp_v1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n chunks from chunk_mem on dut0 with gap idle cycles between beats.
  task automatic run_chunks(input int n, input int gap, input logic [15:0] exp, input bit inject_start);
    bit got;
    start0 = 1'b1;
    num_chunks = 8'(n);
    exp_q.push_back(exp);
    step();
    start0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      bs_valid = 1'b1;
      bs_in = chunk_mem[i];
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = rdy0;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL accept_timeout beat=%0d bs_ready=%b exp=1", i, rdy0);
      end
      step();
      bs_valid = 1'b0;
      bs_in = 32'hDEAD_BEEF;
      if (inject_start && i == 0) begin
        start0 = 1'b1;
        num_chunks = 8'd9;
        step();
        start0 = 1'b0;
        num_chunks = 8'd0;
      end
      for (int g = 0; g < gap && i < n - 1; g++) begin
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin
          failures++;
          $display("FAIL ready_in_gap beat=%0d bs_ready=%b exp=1", i, rdy0);
        end
        step();
      end
    end
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b0 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL drain_cycle result_valid=%b bs_ready=%b exp=0,0", rv0, rdy0);
    end
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b1 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle result_valid=%b busy=%b exp=1,1", rv0, busy0);
    end
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL after_done result_valid=%b busy=%b exp=0,0", rv0, busy0);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (res0 !== 16'd0 || rv0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state result=%0d rv=%b rdy=%b busy=%b exp=0,0,0,0", res0, rv0, rdy0, busy0);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (res0 !== 16'd0 || rv0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_state result=%0d rv=%b rdy=%b busy=%b exp=0,0,0,0", res0, rv0, rdy0, busy0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) chunk_mem[i] = 32'hFFFF_FFFF;
    run_chunks(4, 0, 16'd128, 1'b0);
  endtask

  task automatic test_gaps();
    chunk_mem[0] = 32'h0000_000F;
    chunk_mem[1] = 32'hAAAA_AAAA;
    chunk_mem[2] = 32'h8000_0001;
    run_chunks(3, 2, 16'd22, 1'b0);
  endtask

  task automatic test_zero_chunks();
    start0 = 1'b1;
    num_chunks = 8'd0;
    exp_q.push_back(16'd0);
    step();
    start0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b1 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse result_valid=%b bs_ready=%b exp=1,0", rv0, rdy0);
    end
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL zero_after rv=%b rdy=%b busy=%b exp=0,0,0", rv0, rdy0, busy0);
    end
    step();
  endtask

  task automatic test_start_ignored();
    chunk_mem[0] = 32'h0000_0001;
    chunk_mem[1] = 32'h0000_0003;
    run_chunks(2, 0, 16'd3, 1'b1);
    bs_valid = 1'b1;
    bs_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin
        failures++;
        $display("FAIL not_consumed cyc=%0d bs_ready=%b busy=%b exp=0,0", i, rdy0, busy0);
      end
    end
    step();
    bs_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start0 = 1'b1;
    num_chunks = 8'd5;
    step();
    start0 = 1'b0;
    bs_valid = 1'b1;
    bs_in = 32'hFFFF_FFFF;
    step();
    step();
    bs_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res0 !== 16'd0 || rv0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_state result=%0d rv=%b rdy=%b busy=%b exp=0,0,0,0", res0, rv0, rdy0, busy0);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    chunk_mem[0] = 32'h00FF_00FF;
    run_chunks(1, 0, 16'd16, 1'b0);
  endtask

  task automatic test_full_and_saturation();
    bit seen;
    for (int i = 0; i < 255; i++) chunk_mem[i] = 32'hFFFF_FFFF;
    run_chunks(255, 0, 16'd8160, 1'b0);
    start1 = 1'b1;
    num_chunks = 8'd10;
    exp_q1.push_back(8'd255);
    step();
    start1 = 1'b0;
    bs_valid = 1'b1;
    bs_in = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = rv1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL sat_timeout result_valid=%b exp=1", rv1);
    end
    step();
    bs_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_zero_chunks();
    test_start_ignored();
    test_reset_mid_run();
    test_full_and_saturation();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL pending_results dut0=%0d dut1=%0d exp=0,0", exp_q.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
